// File: rtl/avalon_mm_burst_ram_slave.sv
// Avalon-MM burst slave backed by block RAM; 2-cycle read latency, 1 beat/cycle both ways.
// wait_request high in reset and during read bursts; AMM_SLAVE_BACKPRESSURE_EN adds LFSR stalls.
// Optional feature macro: AMM_SLAVE_BACKPRESSURE_EN.
module avalon_mm_burst_ram_slave #(
  parameter int          ADDR_WIDTH        = 32,
  parameter int          DATA_WIDTH        = 64,
  parameter int          BURST_COUNT_WIDTH = 8,
  parameter int          BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int          MEM_ADDR_WIDTH    = 10,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [ADDR_WIDTH-1:0]        address,
  input  logic [BURST_COUNT_WIDTH-1:0] burst_count,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic [BYTE_ENABLE_WIDTH-1:0] byte_enable,
  input  logic                         write,
  input  logic                         read,
  output logic                         wait_request,
  output logic [DATA_WIDTH-1:0]        read_data,
  output logic                         read_data_val,
  output logic                         err_o
);

  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

  state_t                         state;
  logic [MEM_ADDR_WIDTH-1:0]      ptr;
  logic [BURST_COUNT_WIDTH-1:0]   remaining;
  logic [DATA_WIDTH-1:0]          mem [DEPTH];
  logic                           stall;
  logic                           beat_ok;
  logic [BURST_COUNT_WIDTH-1:0]   n_eff;
  logic [MEM_ADDR_WIDTH-1:0]      wr_addr;
  logic [MEM_ADDR_WIDTH-1:0]      cmd_addr;

`ifdef AMM_SLAVE_BACKPRESSURE_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
  wire unused_seed = &{1'b0, LFSR_SEED};
`endif

  // Only the low address bits reach the RAM; the rest of the word address is ignored.
  wire unused_addr = &{1'b0, address[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

  assign cmd_addr     = address[MEM_ADDR_WIDTH-1:0];
  assign wait_request = rst_i | (state == RD_BURST) | stall;
  assign beat_ok      = write & ~wait_request;
  assign n_eff        = (burst_count == '0) ? BURST_COUNT_WIDTH'(1) : burst_count;
  assign wr_addr      = (state == IDLE) ? cmd_addr : ptr;

  always_ff @(posedge clk_i) begin
    if (beat_ok) begin
      for (int i = 0; i < BYTE_ENABLE_WIDTH; i++) begin
        if (byte_enable[i]) mem[wr_addr][i*8 +: 8] <= write_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      ptr           <= '0;
      remaining     <= '0;
      read_data     <= '0;
      read_data_val <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      read_data_val <= 1'b0;
      case (state)
        IDLE: begin
          if (!wait_request) begin
            if (write) begin
              // A simultaneous read is dropped in favour of the write.
              if (read) err_o <= 1'b1;
              if (n_eff != BURST_COUNT_WIDTH'(1)) begin
                state     <= WR_BURST;
                ptr       <= cmd_addr + MEM_ADDR_WIDTH'(1);
                remaining <= n_eff - BURST_COUNT_WIDTH'(1);
              end
            end else if (read) begin
              state     <= RD_BURST;
              ptr       <= cmd_addr;
              remaining <= n_eff;
            end
          end
        end
        WR_BURST: begin
          if (read) err_o <= 1'b1;
          if (beat_ok) begin
            ptr       <= ptr + MEM_ADDR_WIDTH'(1);
            remaining <= remaining - BURST_COUNT_WIDTH'(1);
            if (remaining == BURST_COUNT_WIDTH'(1)) state <= IDLE;
          end
        end
        RD_BURST: begin
          read_data     <= mem[ptr];
          read_data_val <= 1'b1;
          ptr           <= ptr + MEM_ADDR_WIDTH'(1);
          remaining     <= remaining - BURST_COUNT_WIDTH'(1);
          if (remaining == BURST_COUNT_WIDTH'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_burst_ram_slave.sv
// Directed bench for avalon_mm_burst_ram_slave (default build, MEM_ADDR_WIDTH=10).
module tb_avalon_mm_burst_ram_slave;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] address;
  logic [7:0]  burst_count;
  logic [63:0] write_data;
  logic [7:0]  byte_enable;
  logic        write;
  logic        read;
  logic        wait_request;
  logic [63:0] read_data;
  logic        read_data_val;
  logic        err_o;

  int nvec = 0;
  int nerr = 0;

  logic [63:0] wdat [16];
  logic        rv [40];
  logic [63:0] rd [40];
  logic        rw [40];

  avalon_mm_burst_ram_slave dut (
    .clk_i(clk_i), .rst_i(rst_i), .address(address), .burst_count(burst_count),
    .write_data(write_data), .byte_enable(byte_enable), .write(write), .read(read),
    .wait_request(wait_request), .read_data(read_data), .read_data_val(read_data_val),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Write burst of n beats from wdat[]; gap_mask bit i inserts an idle cycle before beat i.
  task automatic do_write(input logic [31:0] a, input int n, input logic [7:0] be, input int gap_mask);
    for (int i = 0; i < n; i++) begin
      if (gap_mask[i]) begin
        write = 1'b0;
        step();
      end
      write       = 1'b1;
      address     = a;
      burst_count = 8'(n);
      write_data  = wdat[i];
      byte_enable = be;
      step();
    end
    write = 1'b0;
  endtask

  // Issue a read; rv/rd/rw[c] record outputs in cycle T+c after acceptance edge T.
  task automatic do_read(input logic [31:0] a, input int n);
    address     = a;
    burst_count = 8'(n);
    read        = 1'b1;
    step();
    read = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      rv[c] = read_data_val;
      rd[c] = read_data;
      rw[c] = wait_request;
      step();
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; write = 1'b0; read = 1'b0; address = '0; burst_count = '0;
    write_data = '0; byte_enable = '0;
    step(); step();
    nvec++; if (wait_request !== 1'b1) begin nerr++; $display("FAIL reset_wait: got %b expected 1", wait_request); end
    nvec++; if (read_data_val !== 1'b0) begin nerr++; $display("FAIL reset_val: got %b expected 0", read_data_val); end
    nvec++; if (read_data !== 64'h0) begin nerr++; $display("FAIL reset_data: got %h expected 0", read_data); end
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b expected 0", err_o); end
    rst_i = 1'b0;
    #1;
    nvec++; if (wait_request !== 1'b0) begin nerr++; $display("FAIL reset_idle_wait: got %b expected 0", wait_request); end
    step();
  endtask

  task automatic test_single();
    wdat[0] = 64'h0123_4567_89AB_CDEF;
    do_write(32'd5, 1, 8'hFF, 0);
    do_read(32'd5, 1);
    nvec++; if (rv[1] !== 1'b0) begin nerr++; $display("FAIL single_val_t1: got %b expected 0", rv[1]); end
    nvec++; if (rv[2] !== 1'b1) begin nerr++; $display("FAIL single_val_t2: got %b expected 1", rv[2]); end
    nvec++; if (rd[2] !== 64'h0123_4567_89AB_CDEF) begin nerr++; $display("FAIL single_data: got %h expected 0123456789abcdef", rd[2]); end
    nvec++; if (rv[3] !== 1'b0) begin nerr++; $display("FAIL single_val_t3: got %b expected 0", rv[3]); end
  endtask

  task automatic test_burst_gaps();
    int wcnt;
    for (int i = 0; i < 8; i++) wdat[i] = 64'(i);
    do_write(32'd16, 8, 8'hFF, 32'h48);
    do_read(32'd16, 8);
    wcnt = 0;
    for (int c = 1; c <= 10; c++) if (rw[c] === 1'b1) wcnt++;
    nvec++; if (wcnt !== 8) begin nerr++; $display("FAIL burst_wait_cycles: got %0d expected 8", wcnt); end
    nvec++; if (rv[1] !== 1'b0) begin nerr++; $display("FAIL burst_val_t1: got %b expected 0", rv[1]); end
    for (int k = 0; k < 8; k++) begin
      nvec++;
      if (rv[k+2] !== 1'b1 || rd[k+2] !== 64'(k)) begin
        nerr++; $display("FAIL burst_beat%0d: got val=%b data=%h expected val=1 data=%h", k, rv[k+2], rd[k+2], 64'(k));
      end
    end
    nvec++; if (rv[10] !== 1'b0) begin nerr++; $display("FAIL burst_val_end: got %b expected 0", rv[10]); end
  endtask

  task automatic test_byte_enable();
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(32'd3, 1, 8'hFF, 0);
    wdat[0] = 64'h0;
    do_write(32'd3, 1, 8'h0F, 0);
    do_read(32'd3, 1);
    nvec++; if (rv[2] !== 1'b1 || rd[2] !== 64'hFFFF_FFFF_0000_0000) begin
      nerr++; $display("FAIL byte_enable: got val=%b data=%h expected val=1 data=ffffffff00000000", rv[2], rd[2]);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp [4];
    exp[0] = 64'hA0A0; exp[1] = 64'hA1A1; exp[2] = 64'hA2A2; exp[3] = 64'hA3A3;
    for (int i = 0; i < 4; i++) wdat[i] = exp[i];
    do_write(32'd1022, 4, 8'hFF, 0);
    do_read(32'd1022, 4);
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (rv[k+2] !== 1'b1 || rd[k+2] !== exp[k]) begin
        nerr++; $display("FAIL wrap_beat%0d: got val=%b data=%h expected val=1 data=%h", k, rv[k+2], rd[k+2], exp[k]);
      end
    end
    do_read(32'd0, 2);
    nvec++; if (rd[2] !== 64'hA2A2) begin nerr++; $display("FAIL wrap_word0: got %h expected a2a2", rd[2]); end
    nvec++; if (rd[3] !== 64'hA3A3) begin nerr++; $display("FAIL wrap_word1: got %h expected a3a3", rd[3]); end
  endtask

  task automatic test_rw_conflict();
    int vcnt;
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL conflict_err_before: got %b expected 0", err_o); end
    address = 32'd40; burst_count = 8'd1; write_data = 64'hDEAD_BEEF_CAFE_F00D; byte_enable = 8'hFF;
    write = 1'b1; read = 1'b1;
    step();
    write = 1'b0; read = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (read_data_val === 1'b1) vcnt++;
      step();
    end
    nvec++; if (vcnt !== 0) begin nerr++; $display("FAIL conflict_no_read: got %0d valid beats expected 0", vcnt); end
    nvec++; if (err_o !== 1'b1) begin nerr++; $display("FAIL conflict_err: got %b expected 1", err_o); end
    do_read(32'd40, 1);
    nvec++; if (rd[2] !== 64'hDEAD_BEEF_CAFE_F00D) begin nerr++; $display("FAIL conflict_write_data: got %h expected deadbeefcafef00d", rd[2]); end
    nvec++; if (err_o !== 1'b1) begin nerr++; $display("FAIL conflict_err_sticky: got %b expected 1", err_o); end
  endtask

  task automatic test_back_to_back();
    address = 32'd16; burst_count = 8'd2; read = 1'b1;
    step();
    read = 1'b0;
    step();
    step();
    nvec++; if (read_data_val !== 1'b1 || read_data !== 64'd1 || wait_request !== 1'b0) begin
      nerr++; $display("FAIL b2b_last_beat: got val=%b data=%h wait=%b expected val=1 data=1 wait=0", read_data_val, read_data, wait_request);
    end
    address = 32'd20; burst_count = 8'd1; read = 1'b1;
    step();
    read = 1'b0;
    nvec++; if (wait_request !== 1'b1) begin nerr++; $display("FAIL b2b_accepted: got wait=%b expected 1", wait_request); end
    step();
    nvec++; if (read_data_val !== 1'b1 || read_data !== 64'd4) begin
      nerr++; $display("FAIL b2b_second: got val=%b data=%h expected val=1 data=4", read_data_val, read_data);
    end
    step();
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 16; i++) wdat[i] = 64'h5000 + 64'(i);
    do_write(32'd100, 16, 8'hFF, 0);
    address = 32'd100; burst_count = 8'd16; read = 1'b1;
    step();
    read = 1'b0;
    step();
    step();
    nvec++; if (read_data_val !== 1'b1 || read_data !== 64'h5001) begin
      nerr++; $display("FAIL midrst_beat1: got val=%b data=%h expected val=1 data=5001", read_data_val, read_data);
    end
    rst_i = 1'b1;
    #1;
    nvec++; if (wait_request !== 1'b1) begin nerr++; $display("FAIL midrst_wait_rst: got %b expected 1", wait_request); end
    step();
    nvec++; if (read_data_val !== 1'b0) begin nerr++; $display("FAIL midrst_val_drop: got %b expected 0", read_data_val); end
    rst_i = 1'b0;
    #1;
    nvec++; if (wait_request !== 1'b0) begin nerr++; $display("FAIL midrst_wait_after: got %b expected 0", wait_request); end
    nvec++; if (err_o !== 1'b0) begin nerr++; $display("FAIL midrst_err_cleared: got %b expected 0", err_o); end
    step();
    nvec++; if (read_data_val !== 1'b0) begin nerr++; $display("FAIL midrst_val_idle: got %b expected 0", read_data_val); end
    do_read(32'd110, 4);
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (rv[k+2] !== 1'b1 || rd[k+2] !== 64'h500A + 64'(k)) begin
        nerr++; $display("FAIL midrst_reread%0d: got val=%b data=%h expected val=1 data=%h", k, rv[k+2], rd[k+2], 64'h500A + 64'(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_gaps();
    test_byte_enable();
    test_wrap();
    test_rw_conflict();
    test_back_to_back();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
